// File: rtl/dm_mem_arbiter_pkg.sv
// Shared debug-module memory arbiter types: requester count, requester index
// and the lock state encoding.
package dm_mem_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef logic req_idx_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dm_mem_order_fifo.sv
// In-order response routing FIFO: remembers which requester owns each
// granted-but-unanswered downstream transaction.
module dm_mem_order_fifo
  import dm_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  req_idx_t               idx_in,
  output req_idx_t               idx_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  req_idx_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign idx_out = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= idx_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dm_mem_arbiter.sv
// Two-requester round-robin memory arbiter with request locking and
// in-order response routing toward a single downstream master port.
//
// state     | meaning
// ----------+------------------------------------------------------------
// LOCK_IDLE | no pending downstream request; round-robin selection free
// LOCK_HELD | request shown without grant; selection pinned to lock_idx_q
module dm_mem_arbiter
  import dm_mem_arbiter_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]         wdata_i,
  input  logic [NUM_REQ-1:0][XLEN/8-1:0]       be_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   r_valid_o,
  output logic [XLEN-1:0]                      r_rdata_o,
  output logic                                 mst_req_o,
  output logic [ADDR_WIDTH-1:0]                mst_addr_o,
  output logic                                 mst_we_o,
  output logic [XLEN-1:0]                      mst_wdata_o,
  output logic [XLEN/8-1:0]                    mst_be_o,
  input  logic                                 mst_gnt_i,
  input  logic                                 mst_r_valid_i,
  input  logic [XLEN-1:0]                      mst_r_rdata_i,
  output logic                                 busy_o,
  output logic                                 rsp_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  lock_state_e      lock_q;
  req_idx_t         lock_idx_q;
  req_idx_t         prio_q;
  req_idx_t         sel;
  req_idx_t         head_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;

  always_comb begin
    sel = prio_q;
    if (lock_q == LOCK_HELD)  sel = lock_idx_q;
    else if (req_i[prio_q])   sel = prio_q;
    else if (req_i[~prio_q])  sel = ~prio_q;
  end

  // Gating with rst_n keeps the combinational request quiet while in reset.
  assign mst_req_o   = rst_n & req_i[sel] & ~fifo_full;
  assign mst_addr_o  = addr_i[sel];
  assign mst_we_o    = we_i[sel];
  assign mst_wdata_o = wdata_i[sel];
  assign mst_be_o    = be_i[sel];

  assign push      = mst_req_o & mst_gnt_i;
  assign pop       = mst_r_valid_i & ~fifo_empty;
  assign r_rdata_o = mst_r_rdata_i;
  assign busy_o    = (count != '0) | mst_req_o;

  always_comb begin
    gnt_o               = '0;
    r_valid_o           = '0;
    gnt_o[sel]          = push;
    r_valid_o[head_idx] = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= LOCK_IDLE;
      lock_idx_q <= '0;
      prio_q     <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      if (push) prio_q <= ~sel;
      case (lock_q)
        LOCK_IDLE: begin
          if (mst_req_o && !mst_gnt_i) begin
            lock_q     <= LOCK_HELD;
            lock_idx_q <= sel;
          end
        end
        LOCK_HELD: begin
          if (push) lock_q <= LOCK_IDLE;
        end
        default: lock_q <= LOCK_IDLE;
      endcase
      if (mst_r_valid_i && fifo_empty) rsp_err_o <= 1'b1;
    end
  end

  dm_mem_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .idx_in  (sel),
    .idx_out (head_idx),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Bench for dm_mem_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_dm_mem_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int MO   = 4;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic [1:0]                 req_i = '0;
  logic [1:0][AW-1:0]         addr_i;
  logic [1:0]                 we_i;
  logic [1:0][XLEN-1:0]       wdata_i;
  logic [1:0][XLEN/8-1:0]     be_i;
  logic [1:0]                 gnt_o;
  logic [1:0]                 r_valid_o;
  logic [XLEN-1:0]            r_rdata_o;
  logic                       mst_req_o;
  logic [AW-1:0]              mst_addr_o;
  logic                       mst_we_o;
  logic [XLEN-1:0]            mst_wdata_o;
  logic [XLEN/8-1:0]          mst_be_o;
  logic                       mst_gnt_i = 1'b0;
  logic                       mst_r_valid_i = 1'b0;
  logic [XLEN-1:0]            mst_r_rdata_i = '0;
  logic                       busy_o;
  logic                       rsp_err_o;

  always #5 clk = ~clk;

  dm_mem_arbiter #(
    .XLEN            (XLEN),
    .ADDR_WIDTH      (AW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .wdata_i       (wdata_i),
    .be_i          (be_i),
    .gnt_o         (gnt_o),
    .r_valid_o     (r_valid_o),
    .r_rdata_o     (r_rdata_o),
    .mst_req_o     (mst_req_o),
    .mst_addr_o    (mst_addr_o),
    .mst_we_o      (mst_we_o),
    .mst_wdata_o   (mst_wdata_o),
    .mst_be_o      (mst_be_o),
    .mst_gnt_i     (mst_gnt_i),
    .mst_r_valid_i (mst_r_valid_i),
    .mst_r_rdata_i (mst_r_rdata_i),
    .busy_o        (busy_o),
    .rsp_err_o     (rsp_err_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Asserts reset mid-cycle with busy inputs, checks quiet outputs, releases.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    req_i         = 2'b11;
    mst_gnt_i     = 1'b1;
    mst_r_valid_i = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_gnt"},    gnt_o,     2'b00);
    chk({tag, ".rst_rvalid"}, r_valid_o, 2'b00);
    chk({tag, ".rst_mreq"},   mst_req_o, 1'b0);
    chk({tag, ".rst_busy"},   busy_o,    1'b0);
    chk({tag, ".rst_err"},    rsp_err_o, 1'b0);
    @(posedge clk);
    #1;
    req_i         = 2'b00;
    mst_gnt_i     = 1'b0;
    mst_r_valid_i = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic [1:0] rq, input logic g, input logic rv,
                     input logic [31:0] rd, input logic [1:0] eg, input logic [1:0] erv,
                     input logic em, input int es, input logic eb);
    req_i         = rq;
    mst_gnt_i     = g;
    mst_r_valid_i = rv;
    mst_r_rdata_i = rd;
    @(negedge clk);
    chk({tag, ".gnt"},    gnt_o,     eg);
    chk({tag, ".rvalid"}, r_valid_o, erv);
    chk({tag, ".mreq"},   mst_req_o, em);
    chk({tag, ".busy"},   busy_o,    eb);
    if (em)        chk({tag, ".addr"},  mst_addr_o, addr_i[es]);
    if (erv != '0) chk({tag, ".rdata"}, r_rdata_o,  rd);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_mreq;
    int          e_sel;
    logic        e_busy;
  } vec_t;

  vec_t tbl[7];

  // Reference model state for the randomized phase.
  int  q[$];
  int  prio;
  bit  locked;
  int  lidx;
  bit  err;
  bit  pend[2];

  initial begin
    addr_i  = {32'h0000_0200, 32'h0000_0100};
    we_i    = 2'b10;
    wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    be_i    = {4'hF, 4'h3};

    // Alternating grants, then in-order responses 0xA/0xB/0xC.
    tbl[0] = '{2'b11, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00, 1'b1, 0, 1'b1};
    tbl[1] = '{2'b11, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00, 1'b1, 1, 1'b1};
    tbl[2] = '{2'b11, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00, 1'b1, 0, 1'b1};
    tbl[3] = '{2'b00, 1'b1, 1'b1, 32'hA, 2'b00, 2'b01, 1'b0, 0, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 1'b1, 32'hB, 2'b00, 2'b10, 1'b0, 0, 1'b1};
    tbl[5] = '{2'b00, 1'b1, 1'b1, 32'hC, 2'b00, 2'b01, 1'b0, 0, 1'b1};
    tbl[6] = '{2'b00, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 0, 1'b0};

    do_reset("tbl");
    for (int i = 0; i < 7; i++)
      cyc($sformatf("tbl%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata,
          tbl[i].e_gnt, tbl[i].e_rv, tbl[i].e_mreq, tbl[i].e_sel, tbl[i].e_busy);

    // Lock: selection must not switch while a request waits for grant.
    do_reset("lock");
    cyc("lock0", 2'b01, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b1, 0, 1'b1);
    cyc("lock1", 2'b11, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b1, 0, 1'b1);
    cyc("lock2", 2'b11, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b1, 0, 1'b1);
    cyc("lock3", 2'b11, 1'b1, 1'b0, 0, 2'b01, 2'b00, 1'b1, 0, 1'b1);
    cyc("lock4", 2'b10, 1'b1, 1'b0, 0, 2'b10, 2'b00, 1'b1, 1, 1'b1);
    cyc("lock5", 2'b10, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1, 1'b1);
    cyc("lock6", 2'b11, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1, 1'b1);
    cyc("lock7", 2'b11, 1'b1, 1'b0, 0, 2'b10, 2'b00, 1'b1, 1, 1'b1);
    cyc("lock8", 2'b01, 1'b1, 1'b0, 0, 2'b01, 2'b00, 1'b1, 0, 1'b1);

    // Full FIFO: four grants, stall, a response, then granting resumes.
    do_reset("full");
    for (int i = 0; i < MO; i++)
      cyc($sformatf("full_g%0d", i), 2'b10, 1'b1, 1'b0, 0, 2'b10, 2'b00, 1'b1, 1, 1'b1);
    cyc("full_stall", 2'b10, 1'b1, 1'b0, 0,        2'b00, 2'b00, 1'b0, 1, 1'b1);
    cyc("full_pop",   2'b10, 1'b1, 1'b1, 32'h77,   2'b00, 2'b10, 1'b0, 1, 1'b1);
    cyc("full_resume",2'b10, 1'b1, 1'b0, 0,        2'b10, 2'b00, 1'b1, 1, 1'b1);

    // Stray response with nothing outstanding sets a sticky error.
    do_reset("err");
    cyc("err_pulse", 2'b00, 1'b0, 1'b1, 32'h55, 2'b00, 2'b00, 1'b0, 0, 1'b0);
    chk("err_set", rsp_err_o, 1'b1);
    cyc("err_idle0", 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b0, 0, 1'b0);
    cyc("err_idle1", 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b0, 0, 1'b0);
    chk("err_held", rsp_err_o, 1'b1);

    // Reset with two outstanding transactions discards them.
    do_reset("mid");
    cyc("mid_g0", 2'b11, 1'b1, 1'b0, 0, 2'b01, 2'b00, 1'b1, 0, 1'b1);
    cyc("mid_g1", 2'b11, 1'b1, 1'b0, 0, 2'b10, 2'b00, 1'b1, 1, 1'b1);
    do_reset("mid");
    cyc("mid_post", 2'b00, 1'b0, 1'b0, 0,      2'b00, 2'b00, 1'b0, 0, 1'b0);
    cyc("mid_late", 2'b00, 1'b0, 1'b1, 32'h99, 2'b00, 2'b00, 1'b0, 0, 1'b0);
    chk("mid_err", rsp_err_o, 1'b1);

    // Randomized traffic against the queue model.
    do_reset("rnd");
    q.delete();
    prio = 0; locked = 0; lidx = 0; err = 0;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      int  sel;
      bit  e_mreq, e_grant, e_pop;
      logic [1:0] e_gnt, e_rv;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k]    = 1;
          addr_i[k]  = $urandom;
          we_i[k]    = 1'($urandom_range(1));
          wdata_i[k] = $urandom;
          be_i[k]    = 4'($urandom_range(15));
        end
      end
      req_i         = {pend[1], pend[0]};
      mst_gnt_i     = ($urandom_range(3) != 0);
      mst_r_valid_i = (q.size() > 0) && ($urandom_range(1) == 1);
      mst_r_rdata_i = $urandom;

      if (locked)             sel = lidx;
      else if (pend[prio])    sel = prio;
      else if (pend[1-prio])  sel = 1 - prio;
      else                    sel = prio;
      e_mreq  = pend[sel] && (q.size() < MO);
      e_grant = e_mreq && mst_gnt_i;
      e_pop   = mst_r_valid_i && (q.size() > 0);
      e_gnt   = e_grant ? 2'(1 << sel) : 2'b00;
      e_rv    = e_pop ? 2'(1 << q[0]) : 2'b00;

      @(negedge clk);
      chk("rnd.gnt",    gnt_o,     e_gnt);
      chk("rnd.rvalid", r_valid_o, e_rv);
      chk("rnd.mreq",   mst_req_o, e_mreq);
      chk("rnd.busy",   busy_o,    (q.size() > 0) || e_mreq);
      chk("rnd.err",    rsp_err_o, err);
      if (e_mreq) begin
        chk("rnd.addr",  mst_addr_o,  addr_i[sel]);
        chk("rnd.we",    mst_we_o,    we_i[sel]);
        chk("rnd.wdata", mst_wdata_o, wdata_i[sel]);
        chk("rnd.be",    mst_be_o,    be_i[sel]);
      end
      if (e_pop) chk("rnd.rdata", r_rdata_o, mst_r_rdata_i);
      @(posedge clk);
      #1;

      if (mst_r_valid_i && q.size() == 0) err = 1;
      if (e_pop) void'(q.pop_front());
      if (e_grant) begin
        q.push_back(sel);
        prio      = 1 - sel;
        pend[sel] = 0;
      end
      if (!locked && e_mreq && !mst_gnt_i) begin
        locked = 1;
        lidx   = sel;
      end else if (locked && e_grant) begin
        locked = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_mem_arbiter.md
DM_MEM_ARBITER -- requirements
Module: dm_mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of all wdata/rdata buses.
REQ-002 Parameter ADDR_WIDTH, default 32, address width of all address buses.
REQ-003 Parameter MAX_OUTSTANDING, default 4, power of two ≥2, maximum granted-but-unanswered transactions.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  [2]  per-requester request; index 0 = debug module system-bus master, index 1 = secondary requester.
REQ-007 addr_i / we_i / wdata_i / be_i  input  [2][ADDR_WIDTH] / [2] / [2][XLEN] / [2][XLEN/8]  per-requester command.
REQ-008 gnt_o  output  [2]  per-requester grant.
REQ-009 r_valid_o  output  [2]  per-requester read/write response strobe.
REQ-010 r_rdata_o  output  XLEN  shared response data, valid with any r_valid_o bit.
REQ-011 mst_req_o / mst_addr_o / mst_we_o / mst_wdata_o / mst_be_o  output  1 / ADDR_WIDTH / 1 / XLEN / XLEN/8  downstream command toward the AXI adapter.
REQ-012 mst_gnt_i / mst_r_valid_i / mst_r_rdata_i  input  1 / 1 / XLEN  downstream grant, in-order response, response data.
REQ-013 busy_o  output  1  high while any transaction is outstanding or mst_req_o is high.
REQ-014 rsp_err_o  output  1  sticky: mst_r_valid_i arrived with no outstanding transaction.

Function
REQ-015 Protocol on every port: request held with stable command until grant; one response per grant, strictly in grant order.
REQ-016 Arbitration is round-robin: after a grant to requester k, requester 1-k has priority next cycle; after reset, requester 0 has priority.
REQ-017 Once mst_req_o is asserted for requester k without mst_gnt_i, selection SHALL be locked to k until granted (no switch mid-request).
REQ-018 mst_req_o = selected req_i AND NOT full; command outputs mux the selected requester combinationally (zero-cycle request latency).
REQ-019 gnt_o[k] = mst_req_o AND mst_gnt_i AND selected==k; at most one gnt_o bit high per cycle.
REQ-020 Each grant pushes the requester index into an order FIFO of depth MAX_OUTSTANDING.
REQ-021 mst_r_valid_i with FIFO non-empty pops the head; r_valid_o[head]=1 in the same cycle, r_rdata_o = mst_r_rdata_i (zero-cycle response latency).
REQ-022 Full: mst_req_o forced low even if a pop occurs the same cycle; granting resumes the cycle after count < MAX_OUTSTANDING.
REQ-023 Simultaneous grant and response with FIFO non-full and non-empty: push and pop both occur, count unchanged.
REQ-024 Response with FIFO empty: no r_valid_o bit asserted, rsp_err_o set and held until reset.
REQ-025 FIFO pointers wrap modulo MAX_OUTSTANDING; count is log2(MAX_OUTSTANDING)+1 bits wide.
REQ-026 Lock state machine: IDLE (no lock) -> LOCKED(k) when mst_req_o high and mst_gnt_i low; LOCKED(k) -> IDLE on grant; the requester dropping req_i while LOCKED is a protocol violation and is not checked.

Reset
REQ-027 On rst_n low: FIFO empty, count 0, lock IDLE, priority to requester 0, rsp_err_o 0, all gnt_o/r_valid_o/mst_req_o/busy_o 0.
REQ-028 Reset mid-transaction discards outstanding responses silently; responses arriving after reset release are not routed and set rsp_err_o.

Structure
REQ-029 Requester index type and requester count constant (2) belong in the shared SoC debug package.
REQ-030 Order FIFO is one sub-module, dm_mem_order_fifo (push, pop, index in/out, full, empty).
REQ-031 All registers are flip-flops with asynchronous reset on rst_n; no latches.

Verification
REQ-032 Both req_i high at reset release, mst_gnt_i always 1 -> grants alternate 0,1,0,1 on consecutive cycles.
REQ-033 req_i[0] high, mst_gnt_i low 3 cycles, req_i[1] raised cycle 1 -> mst_addr_o stays addr_i[0] until grant on cycle 3, gnt_o[1] next cycle.
REQ-034 5 grants to requester 1, no responses, MAX_OUTSTANDING=4 -> 4 gnt_o[1] pulses then mst_req_o low; one response -> r_valid_o[1]=1, grant resumes next cycle.
REQ-035 Grants 0,1,0, responses 0xA,0xB,0xC -> r_valid_o[0] with 0xA, r_valid_o[1] with 0xB, r_valid_o[0] with 0xC.
REQ-036 mst_r_valid_i pulse with FIFO empty -> no r_valid_o, rsp_err_o=1 until rst_n low.
REQ-037 rst_n pulsed low with 2 outstanding -> all outputs 0, busy_o 0, FIFO empty after release.
